boot_loader: RTL

//  Bootstrap sequencer. Reads a program image from the um245r FIFO and writes it into the 64K RAM.

---
 rtl/boot_loader_if.sv | 23 ++
 rtl/boot_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_if.sv
// Bus bundle between boot_loader and its FIFO / RAM / bus-arbiter neighbours.
// master: the loader side. slave: the FIFO, RAM and grantor side.
interface boot_loader_if;
  logic        _rxf;
  logic        _rd;
  logic [7:0]  uart_d;
  logic        bus_req;
  logic        bus_gnt;
  logic        _addr_oe;
  logic [15:0] address;
  logic [7:0]  data;
  logic        _we;

  modport master (
    input  _rxf, uart_d, bus_gnt,
    output _rd, bus_req, _addr_oe, address, data, _we
  );

  modport slave (
    output _rxf, uart_d, bus_gnt,
    input  _rd, bus_req, _addr_oe, address, data, _we
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: reads a program image (ADDR_HI, ADDR_LO, LEN_HI, LEN_LO, data...)
// from the um245r FIFO and writes it into RAM while holding the CPU in reset.
// Optional trailing checksum byte is enabled with `define BOOT_LOADER_CHECKSUM_EN.
// State-change tracing (LOG) is a simulation facility and is not part of this block.
module boot_loader #(
  parameter int unsigned RD_LEN         = 2,
  parameter int unsigned WE_LEN         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          _mr,
  input  logic          start,
  boot_loader_if.master bif,
  output logic          _cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WAIT_RXF = 4'd1;
  localparam logic [3:0] S_RD_LOW   = 4'd2;
  localparam logic [3:0] S_REQ      = 4'd3;
  localparam logic [3:0] S_SETUP    = 4'd4;
  localparam logic [3:0] S_WE_LOW   = 4'd5;
  localparam logic [3:0] S_HOLD     = 4'd6;
  localparam logic [3:0] S_FINISH   = 4'd7;
  localparam logic [3:0] S_CSUM_ERR = 4'd8;

  localparam logic [1:0] P_HDR  = 2'd0;
  localparam logic [1:0] P_DATA = 2'd1;
  localparam logic [1:0] P_CSUM = 2'd2;

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam logic [3:0] S_AFTER_DATA = S_WAIT_RXF;
`else
  localparam logic [3:0] S_AFTER_DATA = S_FINISH;
`endif

  localparam int unsigned LMAX = (RD_LEN > WE_LEN) ? RD_LEN : WE_LEN;
  localparam int unsigned CW   = $clog2(LMAX + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 2);

  logic [3:0]    r_state;
  logic [1:0]    r_phase;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [TW-1:0] r_tmo;
  logic [15:0]   r_addr;
  logic [7:0]    r_data;
  logic [15:0]   r_len;
  logic          r_err;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]    r_sum;
`endif

  logic w_rd_last;
  logic w_we_last;
  logic w_tmo_armed;
  logic w_tmo_hit;
  logic w_len_zero;

  assign w_rd_last   = (r_cnt == CW'(RD_LEN - 1));
  assign w_we_last   = (r_cnt == CW'(WE_LEN - 1));
  // The wait for the very first header byte is unbounded.
  assign w_tmo_armed = !((r_phase == P_HDR) && (r_idx == 2'd0));
  assign w_tmo_hit   = (TIMEOUT_CYCLES != 0) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_len_zero  = ({r_len[15:8], bif.uart_d} == 16'h0000);

  // Sequencer: header fetch, per-byte read/write handshakes, completion and abort.
  always_ff @(posedge clk or negedge _mr) begin
    if (!_mr) begin
      r_state <= S_IDLE;
      r_phase <= P_HDR;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_WAIT_RXF;
            r_phase <= P_HDR;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_WAIT_RXF: begin
          if (!bif._rxf) begin
            r_state <= S_RD_LOW;
            r_cnt   <= '0;
            r_tmo   <= '0;
          end else if (w_tmo_armed) begin
            if (w_tmo_hit) begin
              r_state <= S_IDLE;
              r_err   <= 1'b1;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
        end
        S_RD_LOW: begin
          if (!w_rd_last) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            case (r_phase)
              P_HDR: begin
                case (r_idx)
                  2'd0:    r_addr[15:8] <= bif.uart_d;
                  2'd1:    r_addr[7:0]  <= bif.uart_d;
                  2'd2:    r_len[15:8]  <= bif.uart_d;
                  default: r_len[7:0]   <= bif.uart_d;
                endcase
                r_idx <= r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                  if (w_len_zero) begin
                    r_state <= S_AFTER_DATA;
                    r_phase <= P_CSUM;
                  end else begin
                    r_state <= S_WAIT_RXF;
                    r_phase <= P_DATA;
                  end
                end else begin
                  r_state <= S_WAIT_RXF;
                end
              end
              P_DATA: begin
                r_data  <= bif.uart_d;
                r_state <= S_REQ;
`ifdef BOOT_LOADER_CHECKSUM_EN
                r_sum   <= r_sum + bif.uart_d;
`endif
              end
              default: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if ((r_sum + bif.uart_d) == 8'h00) begin
                  r_state <= S_FINISH;
                end else begin
                  r_state <= S_CSUM_ERR;
                  r_err   <= 1'b1;
                end
`else
                r_state <= S_FINISH;
`endif
              end
            endcase
          end
        end
        S_REQ: begin
          if (bif.bus_gnt) begin
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_state <= S_WE_LOW;
          r_cnt   <= '0;
        end
        S_WE_LOW: begin
          if (!w_we_last) begin
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          r_addr <= r_addr + 16'd1;
          r_len  <= r_len - 16'd1;
          if (r_len == 16'd1) begin
            r_state <= S_AFTER_DATA;
            r_phase <= P_CSUM;
          end else begin
            r_state <= S_WAIT_RXF;
          end
        end
        S_FINISH:   r_state <= S_IDLE;
        S_CSUM_ERR: r_state <= S_IDLE;
        default:    r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and enables decode straight from state so _mr forces them inactive at once.
  always_comb begin
    bif._rd      = (r_state != S_RD_LOW);
    bif._we      = (r_state != S_WE_LOW);
    bif._addr_oe = !((r_state == S_SETUP) || (r_state == S_WE_LOW) || (r_state == S_HOLD));
    bif.bus_req  = (r_state == S_REQ) || (r_state == S_SETUP) ||
                   (r_state == S_WE_LOW) || (r_state == S_HOLD);
    bif.address  = r_addr;
    bif.data     = r_data;
    busy         = (r_state != S_IDLE);
    done         = (r_state == S_FINISH);
    _cpu_hold    = (r_state == S_IDLE) || (r_state == S_FINISH);
    err          = r_err;
  end

endmodule
